// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is held for the latched Prescale number of clock cycles.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                state_r, state_s;
  logic [BW-1:0]         bit_r, bit_s;
  logic [5:0]            cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_r;
  logic [5:0]            p_r;
  logic                  tx_r, tx_s;
  logic                  busy_r, busy_s;
  logic                  accept_s;
  logic                  last_cyc_s;
  logic [5:0]            p_in_s;

  // p_r never holds 0, so p_r-1 is always a legal last-cycle value for the counter
  assign p_in_s     = (Prescale == 6'd0) ? 6'd1 : Prescale;
  assign last_cyc_s = (cnt_r == (p_r - 6'd1));

  // Next-state, bit index and per-bit cycle counter
  always_comb begin
    state_s  = state_r;
    bit_s    = bit_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 6'd0;
        bit_s = '0;
        if (Data_Valid) begin
          accept_s = 1'b1;
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: begin
        if (last_cyc_s) begin
          cnt_s   = 6'd0;
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + 6'd1;
        end
      end
      DATA: begin
        if (last_cyc_s) begin
          cnt_s = 6'd0;
          if (bit_r == BW'(DATA_WIDTH - 1)) begin
            bit_s   = '0;
            state_s = par_en_r ? PARITY : STOP;
          end else begin
            bit_s   = bit_r + BW'(1);
          end
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      PARITY: begin
        if (last_cyc_s) begin
          cnt_s   = 6'd0;
          state_s = STOP;
        end else begin
          cnt_s   = cnt_r + 6'd1;
        end
      end
      STOP: begin
        if (last_cyc_s) begin
          cnt_s   = 6'd0;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + 6'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
        bit_s   = '0;
      end
    endcase
  end

  // Line level and Busy decoded from the upcoming state so both outputs can be registered
  always_comb begin
    tx_s   = 1'b1;
    busy_s = 1'b0;
    case (state_s)
      IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
      START: begin
        tx_s   = 1'b0;
        busy_s = 1'b1;
      end
      DATA: begin
        tx_s   = data_r[bit_s];
        busy_s = 1'b1;
      end
      PARITY: begin
        tx_s   = par_r;
        busy_s = 1'b1;
      end
      STOP: begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // Control state, counters and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      bit_r   <= '0;
      cnt_r   <= 6'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      bit_r   <= bit_s;
      cnt_r   <= cnt_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
    end
  end

  // Frame settings captured once at acceptance so later input changes cannot disturb the frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_r   <= '0;
      par_en_r <= 1'b0;
      par_r    <= 1'b0;
      p_r      <= 6'd1;
    end else if (accept_s) begin
      data_r   <= P_DATA;
      par_en_r <= PAR_EN;
      par_r    <= parity_bit(P_DATA, PAR_TYP);
      p_r      <= p_in_s;
    end else begin
      data_r   <= data_r;
      par_en_r <= par_en_r;
      par_r    <= par_r;
      p_r      <= p_r;
    end
  end

  assign TX_OUT = tx_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model feeds a per-cycle scoreboard,
// plus directed checks of the documented waveforms and boundary cases.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int model_frames = 0;
  int dut_frames = 0;

  logic [1:0] exp_q[$];   // {tx, busy} expected after each clock edge
  logic       fq[$];      // remaining line levels of the frame in flight
  logic       m_busy;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame is the list of line levels start,d0..d7,[parity],stop, each repeated P times
  initial begin : model
    logic [1:0] e;
    logic       b;
    logic [7:0] d;
    logic       lvl;
    int         p;
    m_busy = 1'b0;
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        fq.delete();
        exp_q.delete();
        m_busy = 1'b0;
      end else begin
        if (fq.size() > 0) begin
          b = fq.pop_front();
          e = {b, 1'b1};
        end else if (!m_busy && Data_Valid) begin
          p = (Prescale == 6'd0) ? 1 : int'(Prescale);
          d = P_DATA;
          for (int k = 0; k < 11; k++) begin
            if (k == 0) lvl = 1'b0;
            else if (k <= 8) lvl = d[k-1];
            else if (k == 9) lvl = (^d) ^ PAR_TYP;
            else lvl = 1'b1;
            if (k != 9 || PAR_EN)
              for (int r = 0; r < p; r++) fq.push_back(lvl);
          end
          model_frames++;
          b = fq.pop_front();
          e = {b, 1'b1};
        end else begin
          e = 2'b10;
        end
        m_busy = e[0];
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares the DUT outputs every cycle against the scoreboard
  initial begin : monitor
    logic [1:0] e;
    logic       prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 2'b10;
        check("sb_tx", 32'(TX_OUT), 32'(e[1]));
        check("sb_busy", 32'(Busy), 32'(e[0]));
        if (Busy && !prev_busy) dut_frames++;
      end
      prev_busy = Busy;
    end
  end

  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = p; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Called at the first negedge after acceptance; samples each bit mid-way and counts Busy cycles
  task automatic capture(input int p, input int nbits, output logic [15:0] bits, output int busy_cyc);
    bits = 16'd0;
    busy_cyc = 0;
    for (int c = 0; c < p * nbits; c++) begin
      if (c > 0) @(negedge CLK);
      if (c % p == p / 2) bits[c / p] = TX_OUT;
      if (Busy) busy_cyc++;
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge CLK);
    check({name, "_idle_tx"}, 32'(TX_OUT), 32'd1);
    check({name, "_idle_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin : stim
    logic [15:0] bits;
    logic [9:0]  seen;
    int          bc;
    RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd1;
    repeat (3) @(negedge CLK);
    check("reset_tx", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // 8N1, P=1, 0xA5: documented line sequence 0,1,0,1,0,0,1,0,1,1
    pulse(8'hA5, 1'b0, 1'b0, 6'd1);
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      seen[i] = TX_OUT;
      if (Busy) bc++;
    end
    check("p1_bits", 32'(seen), 32'(10'b1101001010));
    check("p1_busy_cycles", 32'(bc), 32'd10);
    idle_check("p1");

    // Prescale 0 behaves as 1
    pulse(8'hA5, 1'b0, 1'b0, 6'd0);
    capture(1, 10, bits, bc);
    check("p0_bits", 32'(bits[9:0]), 32'(10'b1101001010));
    check("p0_busy_cycles", 32'(bc), 32'd10);
    idle_check("p0");

    // P=8, 0xA5, even then odd parity
    pulse(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(8, 11, bits, bc);
    check("even_frame", 32'(bits[10:0]), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
    check("even_busy_cycles", 32'(bc), 32'd88);
    idle_check("even");
    pulse(8'hA5, 1'b1, 1'b1, 6'd8);
    capture(8, 11, bits, bc);
    check("odd_parity", 32'(bits[9]), 32'd1);
    check("odd_busy_cycles", 32'(bc), 32'd88);
    idle_check("odd");

    // P=16, 0x00 odd parity; inputs changed right after acceptance
    pulse(8'h00, 1'b1, 1'b1, 6'd16);
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd3;
    capture(16, 11, bits, bc);
    check("iso_data", 32'(bits[8:1]), 32'd0);
    check("iso_parity", 32'(bits[9]), 32'd1);
    check("iso_stop", 32'(bits[10]), 32'd1);
    check("iso_busy_cycles", 32'(bc), 32'd176);
    idle_check("iso");

    // Data_Valid held high, P=4: 40-cycle frames with one idle cycle between
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hC3;
    check("b2b_start_busy", 32'(Busy), 32'd1);
    check("b2b_start_tx", 32'(TX_OUT), 32'd0);
    repeat (40) @(negedge CLK);
    check("b2b_gap_busy", 32'(Busy), 32'd0);
    check("b2b_gap_tx", 32'(TX_OUT), 32'd1);
    @(negedge CLK);
    check("b2b_second_busy", 32'(Busy), 32'd1);
    check("b2b_second_tx", 32'(TX_OUT), 32'd0);
    P_DATA = 8'h3C;
    repeat (40) @(negedge CLK);
    check("b2b_gap2_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (45) @(negedge CLK);

    // Data_Valid pulses while busy, including the last stop cycle, are ignored (P=2, F=20)
    pulse(8'h96, 1'b0, 1'b0, 6'd2);
    repeat (4) @(negedge CLK);
    P_DATA = 8'hFF; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (14) @(negedge CLK);
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("ign_after_busy", 32'(Busy), 32'd0);
    check("ign_after_tx", 32'(TX_OUT), 32'd1);
    idle_check("ign");

    // Reset during data bit 3 (P=8), then a clean 0x5A frame
    pulse(8'h33, 1'b0, 1'b0, 6'd8);
    repeat (34) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("async_rst_tx", 32'(TX_OUT), 32'd1);
    check("async_rst_busy", 32'(Busy), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    pulse(8'h5A, 1'b0, 1'b0, 6'd8);
    capture(8, 10, bits, bc);
    check("post_rst_frame", 32'(bits[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
    check("post_rst_busy_cycles", 32'(bc), 32'd80);
    idle_check("post_rst");

    // Random traffic with inputs changing every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      P_DATA = 8'($urandom);
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      Prescale = 6'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) Data_Valid = 1'($urandom_range(0, 1));
    end
    Data_Valid = 1'b0;
    repeat (80) @(negedge CLK);
    #1;
    check("frame_count", 32'(dut_frames), 32'(model_frames));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

- UART transmitter: serializes one DATA_WIDTH-bit parallel word per frame onto a single line.
- Frame: start bit, data bits LSB first, optional even/odd parity bit, one stop bit.
- Each bit is held for Prescale clock cycles, so it pairs with the oversampling receiver using the same Prescale setting.
- Sits in the UART wrapper between the TX data source (register file / system controller) and the serial output pin.

## Interface
- DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.
- CLK  input  1  system/UART clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-low.
- P_DATA  input  DATA_WIDTH  word to transmit; sampled only on acceptance.
- Data_Valid  input  1  request; level-sensitive, accepted only when Busy=0.
- PAR_EN  input  1  1 = parity bit inserted; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on acceptance.
- Prescale  input  6  clock cycles per bit, legal 1..63; 0 behaves as 1; sampled on acceptance.
- TX_OUT  output  1  serial line; idle high; registered.
- Busy  output  1  high while a frame is in progress; registered.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Reset (asynchronous):** state IDLE, TX_OUT=1, Busy=0, bit and cycle counters 0. A frame in progress is abandoned with no further line activity.
- **IDLE:** TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a rising edge, the following are latched into internal registers: P_DATA, PAR_EN, PAR_TYP, Prescale (0 mapped to 1), and the parity bit.
  - Parity bit = XOR of the data bits when PAR_TYP=0; its inverse when PAR_TYP=1.
  - Next state is START.
- **Input isolation:** changes on P_DATA, PAR_EN, PAR_TYP or Prescale after acceptance do not affect the current frame.
- **START:** TX_OUT=0 for P cycles (P = latched Prescale), then DATA.
- **DATA:** TX_OUT = data[i] for P cycles each, i = 0..DATA_WIDTH-1. Bit index is a counter 0..DATA_WIDTH-1, not a shift loop over P.
  - After the last bit: PARITY if latched PAR_EN=1, else STOP.
- **PARITY:** TX_OUT = parity bit for P cycles, then STOP.
- **STOP:** TX_OUT=1 for P cycles, then IDLE.
- **Cycle counter:** counts 0..P-1 within each bit and wraps to 0 at every bit boundary. It is never compared against a value of P or more.
- **Busy:** 1 in START, DATA, PARITY and STOP. Data_Valid is ignored while Busy=1, including in the last stop cycle.
- **Continuous request:** Data_Valid held high produces back-to-back frames separated by exactly one idle-high cycle.

## Timing
- Let Data_Valid be sampled high with Busy=0 at edge T.
- From edge T+1: TX_OUT=0 and Busy=1. There is no combinational path from any input to TX_OUT or Busy.
- Start bit occupies cycles T+1 .. T+P.
- Data bit i occupies cycles T+1+P*(1+i) .. T+P*(2+i).
- Frame length: F = P*(DATA_WIDTH+2), plus P when parity is enabled. For 8 bits: 10P without parity, 11P with parity.
- Busy is high for exactly F cycles and drops at edge T+F+1. IDLE drives TX_OUT=1 on that same cycle.
- Earliest next acceptance is edge T+F+1, so the next start bit begins at T+F+2.
- Reset asserted mid-frame: TX_OUT=1 and Busy=0 immediately. After release, the first accepted frame behaves identically to one issued after power-up.

## Test plan
- **8N1, P=1, P_DATA=0xA5, PAR_EN=0, single-cycle Data_Valid** -> TX_OUT cycle-by-cycle 0,1,0,1,0,0,1,0,1,1. Busy high for exactly 10 cycles, then TX_OUT=1.
- **P=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0** -> 11 bits of 8 cycles each (88 Busy cycles). Parity bit = 0.
  - Same stimulus with PAR_TYP=1 -> parity bit = 1.
- **P=16, P_DATA=0x00, odd parity** -> parity bit 1. Stop bit high for 16 cycles.
  - Change P_DATA to 0xFF mid-frame -> transmitted data bits remain all 0.
- **Data_Valid held high, P=4, P_DATA alternating 0x3C/0xC3 on each acceptance, PAR_EN=0:**
  - Frames are 40 cycles each, separated by exactly one TX_OUT=1/Busy=0 cycle.
  - The second frame carries the value present at its acceptance edge.
- **Data_Valid pulsed while Busy=1 (P=2)** -> no effect: no extra frame and current bits unchanged.
- **RST asserted during data bit 3 (P=8)** -> TX_OUT=1 and Busy=0 asynchronously. A new 0x5A request after release produces a complete, correct frame.
